radar_signal_gen: RTL and testbench

Synthetic radar timing generator for the radar simulator PL. It produces the ARP (north), ACP (azimuth encoder LSB) and TRIG (transmit) single-cycle pulse trains from programmed periods, paced by the shared microsecond strobe. Its outputs have the same form as the radar inputs consumed by the statistics/measurement path, so a loopback through that path must read back the programmed values.

---
 rtl/radar_signal_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_radar_signal_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_signal_gen.sv
// radar_signal_gen: synthetic radar timing generator producing ARP (north), ACP (azimuth
// increment) and TRIG (transmit) single-cycle pulses, paced by a microsecond strobe.
// Optional macro RADAR_GEN_CFG_LATCH_EN: when defined, CFG_* are captured into shadow
// registers on start and at every north, and validity is checked only at those points.
// When undefined, CFG_* are used live and validity is checked every cycle while running.
`timescale 1ns/1ps
module radar_signal_gen #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  USEC_PE,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] CFG_ARP_US,
  input  logic [DATA_WIDTH-1:0] CFG_ACP_CNT,
  input  logic [DATA_WIDTH-1:0] CFG_TRIG_US,
  output logic                  RADAR_ARP_PE,
  output logic                  RADAR_ACP_PE,
  output logic                  RADAR_TRIG_PE,
  output logic [DATA_WIDTH-1:0] ACP_IDX,
  output logic                  RUNNING,
  output logic                  CFG_ERR
);

  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StStart, StRun} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] arp_cnt_q, arp_cnt_d;
  logic [W-1:0] trig_cnt_q, trig_cnt_d;
  logic [W-1:0] acp_idx_q, acp_idx_d;
  logic [W:0]   acc_q, acc_d;
  logic         arp_pe_q, arp_pe_d;
  logic         acp_pe_q, acp_pe_d;
  logic         trig_pe_q, trig_pe_d;
  logic         cfg_err_q, cfg_err_d;

  // Effective configuration used by the tick datapath
  logic [W-1:0] arp_us, acp_cnt, trig_us;
  logic         cfg_valid;
  logic [W:0]   arp_next, trig_next, acc_sum;
  logic         arp_wrap, trig_wrap, acp_step;
  logic         do_tick, clr_cnt;

  // Validity is always judged on the live inputs; that is what gets latched or used next.
  assign cfg_valid = (CFG_ARP_US >= W'(2)) && (CFG_ACP_CNT != '0) &&
                     (CFG_ACP_CNT <= CFG_ARP_US) && (CFG_TRIG_US != '0);

`ifdef RADAR_GEN_CFG_LATCH_EN
  logic [W-1:0] arp_us_q, acp_cnt_q, trig_us_q;
  logic         latch_cfg;

  // Shadow config, captured on start and at every north
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      arp_us_q  <= '0;
      acp_cnt_q <= '0;
      trig_us_q <= '0;
    end else if (latch_cfg) begin
      arp_us_q  <= CFG_ARP_US;
      acp_cnt_q <= CFG_ACP_CNT;
      trig_us_q <= CFG_TRIG_US;
    end
  end

  assign arp_us  = arp_us_q;
  assign acp_cnt = acp_cnt_q;
  assign trig_us = trig_us_q;
`else
  assign arp_us  = CFG_ARP_US;
  assign acp_cnt = CFG_ACP_CNT;
  assign trig_us = CFG_TRIG_US;
`endif

  // One extra bit keeps the +1 and the accumulator sum from wrapping
  assign arp_next  = {1'b0, arp_cnt_q} + (W+1)'(1);
  assign trig_next = {1'b0, trig_cnt_q} + (W+1)'(1);
  assign acc_sum   = acc_q + {1'b0, acp_cnt};
  // >= rather than == so a period shortened below the running count wraps immediately
  assign arp_wrap  = arp_next >= {1'b0, arp_us};
  assign trig_wrap = trig_next >= {1'b0, trig_us};
  assign acp_step  = acc_sum >= {1'b0, arp_us};

  // Next-state, counter and pulse logic
  always_comb begin
    state_d    = state_q;
    arp_cnt_d  = arp_cnt_q;
    trig_cnt_d = trig_cnt_q;
    acc_d      = acc_q;
    acp_idx_d  = acp_idx_q;
    arp_pe_d   = 1'b0;
    acp_pe_d   = 1'b0;
    trig_pe_d  = 1'b0;
    cfg_err_d  = cfg_err_q;
    do_tick    = 1'b0;
    clr_cnt    = 1'b0;
`ifdef RADAR_GEN_CFG_LATCH_EN
    latch_cfg  = 1'b0;
`endif

    if (!ENABLE) begin
      state_d = StIdle;
      clr_cnt = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          clr_cnt = 1'b1;
          if (cfg_valid) begin
            // The START cycle is the one in which the north pulses are visible
            state_d   = StStart;
            arp_pe_d  = 1'b1;
            acp_pe_d  = 1'b1;
            trig_pe_d = 1'b1;
            cfg_err_d = 1'b0;
`ifdef RADAR_GEN_CFG_LATCH_EN
            latch_cfg = 1'b1;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        StStart: begin
          clr_cnt = 1'b1;
          state_d = StRun;
        end
        StRun: begin
`ifdef RADAR_GEN_CFG_LATCH_EN
          if (USEC_PE) begin
            if (arp_wrap && !cfg_valid) begin
              cfg_err_d = 1'b1;
              state_d   = StIdle;
              clr_cnt   = 1'b1;
            end else begin
              do_tick   = 1'b1;
              latch_cfg = arp_wrap;
            end
          end
`else
          if (!cfg_valid) begin
            cfg_err_d = 1'b1;
            state_d   = StIdle;
            clr_cnt   = 1'b1;
          end else if (USEC_PE) begin
            do_tick = 1'b1;
          end
`endif
        end
        default: begin
          state_d = StIdle;
          clr_cnt = 1'b1;
        end
      endcase
    end

    if (do_tick) begin
      if (arp_wrap) begin
        arp_pe_d  = 1'b1;
        acp_pe_d  = 1'b1;
        arp_cnt_d = '0;
        acc_d     = '0;
        acp_idx_d = '0;
      end else begin
        arp_cnt_d = arp_next[W-1:0];
        // Bresenham spread: ACP_CNT/ARP_US pulses per tick, at most one per tick
        if (acp_step) begin
          acc_d     = acc_sum - {1'b0, arp_us};
          acp_pe_d  = 1'b1;
          acp_idx_d = acp_idx_q + W'(1);
        end else begin
          acc_d = acc_sum;
        end
      end
      // TRIG free-runs; it is deliberately not realigned at north
      if (trig_wrap) begin
        trig_pe_d  = 1'b1;
        trig_cnt_d = '0;
      end else begin
        trig_cnt_d = trig_next[W-1:0];
      end
    end

    if (clr_cnt) begin
      arp_cnt_d  = '0;
      trig_cnt_d = '0;
      acc_d      = '0;
      acp_idx_d  = '0;
    end
  end

  // State, counters and registered pulse outputs
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q    <= StIdle;
      arp_cnt_q  <= '0;
      trig_cnt_q <= '0;
      acc_q      <= '0;
      acp_idx_q  <= '0;
      arp_pe_q   <= 1'b0;
      acp_pe_q   <= 1'b0;
      trig_pe_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      arp_cnt_q  <= arp_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      acc_q      <= acc_d;
      acp_idx_q  <= acp_idx_d;
      arp_pe_q   <= arp_pe_d;
      acp_pe_q   <= acp_pe_d;
      trig_pe_q  <= trig_pe_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign RADAR_ARP_PE  = arp_pe_q;
  assign RADAR_ACP_PE  = acp_pe_q;
  assign RADAR_TRIG_PE = trig_pe_q;
  assign ACP_IDX       = acp_idx_q;
  assign RUNNING       = (state_q != StIdle);
  assign CFG_ERR       = cfg_err_q;

endmodule

// File: tb/tb_radar_signal_gen.sv
// Bench for radar_signal_gen: directed scenarios with literal expectations plus randomized
// stimulus, all outputs compared every cycle against a tick-based behavioural model.
`timescale 1ns/1ps
module tb_radar_signal_gen;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          usec = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] cfg_arp = 32'd1000;
  logic [DW-1:0] cfg_acp = 32'd4;
  logic [DW-1:0] cfg_trig = 32'd300;
  logic          arp_pe, acp_pe, trig_pe, running, cfg_err;
  logic [DW-1:0] acp_idx;

  int checks = 0;
  int failures = 0;

  radar_signal_gen #(.DATA_WIDTH(DW)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .USEC_PE       (usec),
    .ENABLE        (en),
    .CFG_ARP_US    (cfg_arp),
    .CFG_ACP_CNT   (cfg_acp),
    .CFG_TRIG_US   (cfg_trig),
    .RADAR_ARP_PE  (arp_pe),
    .RADAR_ACP_PE  (acp_pe),
    .RADAR_TRIG_PE (trig_pe),
    .ACP_IDX       (acp_idx),
    .RUNNING       (running),
    .CFG_ERR       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position within a rotation is a tick count t since north; the ACP index is
  // floor(t*ACP_CNT/ARP_US) and an ACP pulse fires whenever that value steps.
  logic            m_run, m_start, m_err, e_arp, e_acp, e_trig;
  longint unsigned m_t, m_tt, m_idx, s_arp, s_acp, s_trig;

  task automatic model_abort();
    m_err = 1'b1;
    m_run = 1'b0;
    m_idx = 0;
  endtask

  task automatic model_advance(input longint unsigned a, input longint unsigned c,
                               input longint unsigned tr, output logic north);
    north = 1'b0;
    if (m_t + 1 >= a) begin
      e_arp = 1'b1;
      e_acp = 1'b1;
      m_t   = 0;
      m_idx = 0;
      north = 1'b1;
    end else begin
      m_t = m_t + 1;
      if ((m_t * c) / a > ((m_t - 1) * c) / a) begin
        e_acp = 1'b1;
        m_idx = (m_t * c) / a;
      end
    end
    if (m_tt + 1 >= tr) begin
      e_trig = 1'b1;
      m_tt   = 0;
    end else begin
      m_tt = m_tt + 1;
    end
  endtask

  task automatic model_step();
    logic v;
    logic north;
    v = (cfg_arp >= 2) && (cfg_acp >= 1) && (cfg_acp <= cfg_arp) && (cfg_trig >= 1);
    e_arp  = 1'b0;
    e_acp  = 1'b0;
    e_trig = 1'b0;
    if (!en) begin
      m_run   = 1'b0;
      m_start = 1'b0;
      m_idx   = 0;
    end else if (m_start) begin
      m_start = 1'b0;
      m_run   = 1'b1;
    end else if (!m_run) begin
      if (v) begin
        m_start = 1'b1;
        e_arp   = 1'b1;
        e_acp   = 1'b1;
        e_trig  = 1'b1;
        m_err   = 1'b0;
        m_idx   = 0;
        m_t     = 0;
        m_tt    = 0;
        s_arp   = cfg_arp;
        s_acp   = cfg_acp;
        s_trig  = cfg_trig;
      end else begin
        m_err = 1'b1;
      end
    end else begin
`ifdef RADAR_GEN_CFG_LATCH_EN
      if (usec) begin
        if (m_t + 1 >= s_arp && !v) begin
          model_abort();
        end else begin
          model_advance(s_arp, s_acp, s_trig, north);
          if (north) begin
            s_arp  = cfg_arp;
            s_acp  = cfg_acp;
            s_trig = cfg_trig;
          end
        end
      end
`else
      if (!v) model_abort();
      else if (usec) model_advance(cfg_arp, cfg_acp, cfg_trig, north);
`endif
    end
  endtask

  initial begin
    {m_run, m_start, m_err, e_arp, e_acp, e_trig} = '0;
    m_t = 0; m_tt = 0; m_idx = 0; s_arp = 0; s_acp = 0; s_trig = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        {m_run, m_start, m_err, e_arp, e_acp, e_trig} = '0;
        m_t = 0; m_tt = 0; m_idx = 0;
      end else begin
        model_step();
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("arp_pe", arp_pe, e_arp);
      check("acp_pe", acp_pe, e_acp);
      check("trig_pe", trig_pe, e_trig);
      check("acp_idx", acp_idx, m_idx);
      check("running", running, m_run | m_start);
      check("cfg_err", cfg_err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_idx", acp_idx, 0);
    check("rst_pulses", {arp_pe, acp_pe, trig_pe}, 0);
    check("rst_err", cfg_err, 0);
    rst_n = 1'b1;

    // Nominal rotation with the strobe held high: one tick per cycle
    @(negedge clk);
    usec = 1'b1; cfg_arp = 1000; cfg_acp = 4; cfg_trig = 300; en = 1'b1;
    for (int c = 0; c < 1205; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          check("start_pulses", {arp_pe, acp_pe, trig_pe}, 3'b111);
          check("start_running", running, 1);
        end
        1:    check("run_quiet", {arp_pe, acp_pe, trig_pe}, 0);
        250:  check("pre_acp1", acp_pe, 0);
        251: begin
          check("acp1", acp_pe, 1);
          check("acp1_idx", acp_idx, 1);
          check("model_acp1_idx", m_idx, 1);
        end
        301:  check("trig300", trig_pe, 1);
        501:  check("acp2_idx", acp_idx, 2);
        751:  check("acp3_idx", acp_idx, 3);
        1000: check("pre_north_idx", acp_idx, 3);
        1001: begin
          check("arp1000", arp_pe, 1);
          check("arp1000_acp", acp_pe, 1);
          check("north_idx", acp_idx, 0);
        end
        1201: check("trig1200", trig_pe, 1);
        default: ;
      endcase
    end

    // Stop at tick 400, then restart at north
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < 402; c++) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("stop_running", running, 0);
    check("stop_pulses", {arp_pe, acp_pe, trig_pe}, 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("restart_arp", arp_pe, 1);
    check("restart_idx", acp_idx, 0);

    // Invalid ACP count, then the maximal valid one
    en = 1'b0;
    @(negedge clk);
    cfg_acp = 1001; en = 1'b1;
    @(negedge clk);
    check("bad_err", cfg_err, 1);
    check("bad_running", running, 0);
    check("bad_pulses", {arp_pe, acp_pe, trig_pe}, 0);
    cfg_acp = 1000;
    @(negedge clk);
    check("good_err", cfg_err, 0);
    check("good_start", arp_pe, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("every_tick_acp", acp_pe, 1);
        check("every_tick_idx", acp_idx, 4);
      end
    end

    // Asynchronous reset mid-rotation
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_running", running, 0);
    check("async_rst_idx", acp_idx, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("post_rst_quiet", arp_pe, 0);
    @(negedge clk);
    check("post_rst_start", arp_pe, 1);

    // Shorten ARP period from 1000 to 500 after tick 600
    en = 1'b0;
    @(negedge clk);
    cfg_arp = 1000; cfg_acp = 4; cfg_trig = 300; en = 1'b1;
    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
`ifdef RADAR_GEN_CFG_LATCH_EN
      if (c == 602)  check("latched_no_early_arp", arp_pe, 0);
      if (c == 1001) check("latched_arp1000", arp_pe, 1);
      if (c == 1501) check("latched_arp1500", arp_pe, 1);
`else
      if (c == 602)  check("live_arp601", arp_pe, 1);
      if (c == 1101) check("live_pre_arp", arp_pe, 0);
      if (c == 1102) check("live_arp1101", arp_pe, 1);
`endif
      if (c == 601) cfg_arp = 500;
    end

    // Randomized configurations, strobe pattern, enable drops and TRIG edits
    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
      cfg_arp  = $urandom_range(40, 1);
      cfg_acp  = $urandom_range(cfg_arp + 1, 0);
      cfg_trig = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(15, 1);
      en = 1'b1;
      for (int n = 0; n < int'($urandom_range(300, 60)); n++) begin
        @(negedge clk);
        usec = $urandom_range(1, 0) == 1;
        if ($urandom_range(99, 0) == 0) cfg_trig = $urandom_range(12, 0);
        if ($urandom_range(199, 0) == 0) en = ~en;
      end
    end

    en = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
